// File: rtl/pipeline_cpu.sv
// Five-stage in-order MIPS-subset pipeline (IF/ID/EX/MEM/WB) with EX forwarding,
// load-use stall and branch/jump resolved in ID.

module pipeline_cpu_pc (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        en_i,
    input  logic [31:0] pc_d_i,
    output logic [31:0] pc_o
);
    always_ff @(posedge clk_i) begin
        if (rst_i)     pc_o <= '0;
        else if (en_i) pc_o <= pc_d_i;
    end
endmodule

module pipeline_cpu_regfile (
    input  logic        clk_i,
    input  logic        we_i,
    input  logic [4:0]  waddr_i,
    input  logic [31:0] wdata_i,
    input  logic [4:0]  ra1_i,
    input  logic [4:0]  ra2_i,
    output logic [31:0] rd1_o,
    output logic [31:0] rd2_o
);
    logic [31:0] register [0:31];

    always_ff @(posedge clk_i) begin
        if (we_i && waddr_i != 5'd0) register[waddr_i] <= wdata_i;
    end

    // Same-cycle WB write is bypassed so ID sees the value being written.
    always_comb begin
        rd1_o = register[ra1_i];
        if (ra1_i == 5'd0)                     rd1_o = '0;
        else if (we_i && waddr_i == ra1_i)     rd1_o = wdata_i;
        rd2_o = register[ra2_i];
        if (ra2_i == 5'd0)                     rd2_o = '0;
        else if (we_i && waddr_i == ra2_i)     rd2_o = wdata_i;
    end
endmodule

module pipeline_cpu_imem #(
    parameter int WORDS = 256
) (
    input  logic                     clk_i,
    input  logic                     we_i,
    input  logic [$clog2(WORDS)-1:0] waddr_i,
    input  logic [31:0]              wdata_i,
    input  logic [$clog2(WORDS)-1:0] addr_i,
    output logic [31:0]              instr_o
);
    logic [31:0] memory [0:WORDS-1];

    always_ff @(posedge clk_i) begin
        if (we_i) memory[waddr_i] <= wdata_i;
    end

    assign instr_o = memory[addr_i];
endmodule

module pipeline_cpu_dmem #(
    parameter int BYTES = 32
) (
    input  logic                     clk_i,
    input  logic                     we_i,
    input  logic [$clog2(BYTES)-1:0] addr_i,
    input  logic [31:0]              wdata_i,
    output logic [31:0]              rdata_o
);
    localparam int AW = $clog2(BYTES);

    logic [7:0]    memory [0:BYTES-1];
    logic [AW-1:0] a1, a2, a3;

    assign a1 = addr_i + AW'(1);
    assign a2 = addr_i + AW'(2);
    assign a3 = addr_i + AW'(3);

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            memory[addr_i] <= wdata_i[7:0];
            memory[a1]     <= wdata_i[15:8];
            memory[a2]     <= wdata_i[23:16];
            memory[a3]     <= wdata_i[31:24];
        end
    end

    assign rdata_o = {memory[a3], memory[a2], memory[a1], memory[addr_i]};
endmodule

module pipeline_cpu_hazard (
    input  logic       idex_mem_read_i,
    input  logic [4:0] idex_rt_i,
    input  logic [4:0] ifid_rs_i,
    input  logic [4:0] ifid_rt_i,
    output logic       MUX_Control_hazard_o
);
    assign MUX_Control_hazard_o = !(idex_mem_read_i &&
                                    (idex_rt_i == ifid_rs_i || idex_rt_i == ifid_rt_i));
endmodule

module pipeline_cpu_flush (
    input  logic is_beq_i,
    input  logic is_j_i,
    input  logic eq_i,
    input  logic no_stall_i,
    output logic flush_o
);
    // A stalled branch is held in ID and resolved again next cycle.
    assign flush_o = no_stall_i && (is_j_i || (is_beq_i && eq_i));
endmodule

module pipeline_cpu #(
    parameter int IMEM_WORDS = 256,
    parameter int DMEM_BYTES = 32
) (
    input logic clk_i,
    input logic rst_i,
    input logic start_i
);
    localparam int IA_W = $clog2(IMEM_WORDS);
    localparam int DA_W = $clog2(DMEM_BYTES);

    typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_MUL} alu_op_e;

    typedef struct packed {
        logic    reg_write;
        logic    mem_to_reg;
        logic    mem_read;
        logic    mem_write;
        logic    alu_src;
        alu_op_e alu_op;
    } ctrl_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc4;
    } ifid_t;

    typedef struct packed {
        ctrl_t       ctrl;
        logic [31:0] rs_data;
        logic [31:0] rt_data;
        logic [31:0] imm;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  dest;
    } idex_t;

    typedef struct packed {
        logic        reg_write;
        logic        mem_to_reg;
        logic        mem_write;
        logic [31:0] alu;
        logic [31:0] store;
        logic [4:0]  dest;
    } exmem_t;

    typedef struct packed {
        logic        reg_write;
        logic        mem_to_reg;
        logic [31:0] alu;
        logic [31:0] load;
        logic [4:0]  dest;
    } memwb_t;

    ifid_t  ifid_q,  ifid_d;
    idex_t  idex_q,  idex_d;
    exmem_t exmem_q, exmem_d;
    memwb_t memwb_q, memwb_d;

    logic [31:0] pc, pc_plus4, pc_next, instr;
    logic        no_stall, flush;
    logic [31:0] rs_data, rt_data, wb_data, br_target, load_data;
    logic        wb_we;

    // ---------------- IF ----------------
    assign pc_plus4 = pc + 32'd4;
    assign pc_next  = flush ? br_target : pc_plus4;

    pipeline_cpu_pc PC (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .en_i   (start_i && no_stall),
        .pc_d_i (pc_next),
        .pc_o   (pc)
    );

    // Write port tied off: program contents are loaded from outside the design.
    pipeline_cpu_imem #(.WORDS(IMEM_WORDS)) Instruction_Memory (
        .clk_i   (clk_i),
        .we_i    (1'b0),
        .waddr_i ('0),
        .wdata_i ('0),
        .addr_i  (pc[IA_W+1:2]),
        .instr_o (instr)
    );

    always_comb begin
        if (!no_stall)             ifid_d = ifid_q;
        else if (flush || !start_i) ifid_d = '0;
        else                       ifid_d = '{instr: instr, pc4: pc_plus4};
    end

    // ---------------- ID ----------------
    logic [5:0]  id_op, id_funct;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic [31:0] id_imm;
    logic        id_beq, id_j;
    logic        unused_shamt;

    assign id_op        = ifid_q.instr[31:26];
    assign id_rs        = ifid_q.instr[25:21];
    assign id_rt        = ifid_q.instr[20:16];
    assign id_rd        = ifid_q.instr[15:11];
    assign id_funct     = ifid_q.instr[5:0];
    assign id_imm       = {{16{ifid_q.instr[15]}}, ifid_q.instr[15:0]};
    assign unused_shamt = ^ifid_q.instr[10:6];

    pipeline_cpu_regfile Registers (
        .clk_i   (clk_i),
        .we_i    (wb_we),
        .waddr_i (memwb_q.dest),
        .wdata_i (wb_data),
        .ra1_i   (id_rs),
        .ra2_i   (id_rt),
        .rd1_o   (rs_data),
        .rd2_o   (rt_data)
    );

    pipeline_cpu_hazard HazardDetection (
        .idex_mem_read_i      (idex_q.ctrl.mem_read),
        .idex_rt_i            (idex_q.dest),
        .ifid_rs_i            (id_rs),
        .ifid_rt_i            (id_rt),
        .MUX_Control_hazard_o (no_stall)
    );

    pipeline_cpu_flush Flush (
        .is_beq_i   (id_beq),
        .is_j_i     (id_j),
        .eq_i       (rs_data == rt_data),
        .no_stall_i (no_stall),
        .flush_o    (flush)
    );

    assign br_target = id_j ? {ifid_q.pc4[31:28], ifid_q.instr[25:0], 2'b00}
                            : ifid_q.pc4 + {id_imm[29:0], 2'b00};

    always_comb begin
        ctrl_t c;
        logic [4:0] dest;
        c      = '0;
        dest   = id_rt;
        id_beq = 1'b0;
        id_j   = 1'b0;
        case (id_op)
            6'h00: begin
                dest        = id_rd;
                c.reg_write = 1'b1;
                case (id_funct)
                    6'h20:   c.alu_op = ALU_ADD;
                    6'h22:   c.alu_op = ALU_SUB;
                    6'h24:   c.alu_op = ALU_AND;
                    6'h25:   c.alu_op = ALU_OR;
                    6'h18:   c.alu_op = ALU_MUL;
                    default: c.reg_write = 1'b0;
                endcase
            end
            6'h08: begin c.reg_write = 1'b1; c.alu_src = 1'b1; end
            6'h23: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = 1'b1;
                c.mem_read   = 1'b1;
                c.alu_src    = 1'b1;
            end
            6'h2B: begin c.mem_write = 1'b1; c.alu_src = 1'b1; end
            6'h04: id_beq = 1'b1;
            6'h02: id_j   = 1'b1;
            default: ;
        endcase

        if (!no_stall) idex_d = '0;
        else idex_d = '{ctrl: c, rs_data: rs_data, rt_data: rt_data, imm: id_imm,
                        rs: id_rs, rt: id_rt, dest: dest};
    end

    // ---------------- EX ----------------
    logic [31:0] fwd_a, fwd_b, alu_b, alu_res;

    always_comb begin
        fwd_a = idex_q.rs_data;
        if (exmem_q.reg_write && exmem_q.dest != 5'd0 && exmem_q.dest == idex_q.rs)
            fwd_a = exmem_q.alu;
        else if (memwb_q.reg_write && memwb_q.dest != 5'd0 && memwb_q.dest == idex_q.rs)
            fwd_a = wb_data;

        fwd_b = idex_q.rt_data;
        if (exmem_q.reg_write && exmem_q.dest != 5'd0 && exmem_q.dest == idex_q.rt)
            fwd_b = exmem_q.alu;
        else if (memwb_q.reg_write && memwb_q.dest != 5'd0 && memwb_q.dest == idex_q.rt)
            fwd_b = wb_data;

        alu_b = idex_q.ctrl.alu_src ? idex_q.imm : fwd_b;

        case (idex_q.ctrl.alu_op)
            ALU_ADD: alu_res = fwd_a + alu_b;
            ALU_SUB: alu_res = fwd_a - alu_b;
            ALU_AND: alu_res = fwd_a & alu_b;
            ALU_OR:  alu_res = fwd_a | alu_b;
            ALU_MUL: alu_res = fwd_a * alu_b;
            default: alu_res = '0;
        endcase

        exmem_d = '{reg_write: idex_q.ctrl.reg_write, mem_to_reg: idex_q.ctrl.mem_to_reg,
                    mem_write: idex_q.ctrl.mem_write, alu: alu_res, store: fwd_b,
                    dest: idex_q.dest};
    end

    // ---------------- MEM ----------------
    pipeline_cpu_dmem #(.BYTES(DMEM_BYTES)) DataMemory (
        .clk_i   (clk_i),
        .we_i    (exmem_q.mem_write && !rst_i),
        .addr_i  (exmem_q.alu[DA_W-1:0]),
        .wdata_i (exmem_q.store),
        .rdata_o (load_data)
    );

    always_comb begin
        memwb_d = '{reg_write: exmem_q.reg_write, mem_to_reg: exmem_q.mem_to_reg,
                    alu: exmem_q.alu, load: load_data, dest: exmem_q.dest};
    end

    // ---------------- WB ----------------
    // Architectural state is left untouched by an in-flight instruction during reset.
    assign wb_data = memwb_q.mem_to_reg ? memwb_q.load : memwb_q.alu;
    assign wb_we   = memwb_q.reg_write && !rst_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ifid_q  <= '0;
            idex_q  <= '0;
            exmem_q <= '0;
            memwb_q <= '0;
        end else begin
            ifid_q  <= ifid_d;
            idex_q  <= idex_d;
            exmem_q <= exmem_d;
            memwb_q <= memwb_d;
        end
    end
endmodule

// File: tb/tb_pipeline_cpu.sv
// Directed program tests plus random straight-line programs checked against an
// instruction-level reference model of the ISA.

module tb_pipeline_cpu;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;
    int   stalls, flushes;

    logic [31:0] mreg [32];
    logic [7:0]  mmem [32];
    logic [31:0] snap_reg [32];
    logic [7:0]  snap_mem [32];

    pipeline_cpu dut (.clk_i(clk), .rst_i(rst), .start_i(start));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rtype(input logic [5:0] f, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [4:0] rd);
        return {6'h00, rs, rt, rd, 5'd0, f};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    task automatic clear_imem();
        for (int i = 0; i < 256; i++) dut.Instruction_Memory.memory[i] = 32'h0;
    endtask

    task automatic boot();
        rst = 1'b1; start = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0; start = 1'b1;
        stalls = 0; flushes = 0;
    endtask

    task automatic run(input int n);
        for (int c = 0; c < n; c++) begin
            @(posedge clk); #1;
            if (!dut.HazardDetection.MUX_Control_hazard_o) stalls++;
            if (dut.Flush.flush_o) flushes++;
        end
    endtask

    initial begin
        // Reset state
        @(posedge clk); #1;
        chk("reset pc", dut.PC.pc_o, 32'h0);
        chk("reset hazard", 32'(dut.HazardDetection.MUX_Control_hazard_o), 32'h1);
        chk("reset flush", 32'(dut.Flush.flush_o), 32'h0);

        // Back-to-back ALU dependency through forwarding
        clear_imem();
        dut.Registers.register[1] = 32'd3;
        dut.Registers.register[2] = 32'd4;
        dut.Instruction_Memory.memory[0] = rtype(6'h20, 5'd1, 5'd2, 5'd3);
        dut.Instruction_Memory.memory[1] = rtype(6'h22, 5'd3, 5'd1, 5'd4);
        boot(); run(10);
        chk("fwd r3", dut.Registers.register[3], 32'd7);
        chk("fwd r4", dut.Registers.register[4], 32'd4);
        chk("fwd stalls", 32'(stalls), 32'd0);

        // Load-use stall
        clear_imem();
        dut.DataMemory.memory[0] = 8'd5; dut.DataMemory.memory[1] = 8'd0;
        dut.DataMemory.memory[2] = 8'd0; dut.DataMemory.memory[3] = 8'd0;
        dut.Instruction_Memory.memory[0] = itype(6'h23, 5'd0, 5'd8, 16'd0);
        dut.Instruction_Memory.memory[1] = itype(6'h08, 5'd8, 5'd9, 16'd1);
        boot(); run(12);
        chk("lu stalls", 32'(stalls), 32'd1);
        chk("lu r8", dut.Registers.register[8], 32'd5);
        chk("lu r9", dut.Registers.register[9], 32'd6);

        // Taken beq: flushed slot never writes, one word skipped
        clear_imem();
        for (int r = 10; r <= 12; r++) dut.Registers.register[r] = 32'h0;
        dut.Instruction_Memory.memory[0] = itype(6'h04, 5'd0, 5'd0, 16'd2);
        dut.Instruction_Memory.memory[1] = itype(6'h08, 5'd0, 5'd10, 16'd1);
        dut.Instruction_Memory.memory[2] = itype(6'h08, 5'd0, 5'd11, 16'd2);
        dut.Instruction_Memory.memory[3] = itype(6'h08, 5'd0, 5'd12, 16'd3);
        boot(); run(1);
        chk("beq flush", 32'(dut.Flush.flush_o), 32'h1);
        run(1);
        chk("beq pc", dut.PC.pc_o, 32'd12);
        run(10);
        chk("beq flushes", 32'(flushes), 32'd1);
        chk("beq r10", dut.Registers.register[10], 32'd0);
        chk("beq r11", dut.Registers.register[11], 32'd0);
        chk("beq r12", dut.Registers.register[12], 32'd3);

        // Jump
        clear_imem();
        dut.Registers.register[13] = 32'h0;
        dut.Registers.register[14] = 32'h0;
        dut.Instruction_Memory.memory[0]  = {6'h02, 26'h10};
        dut.Instruction_Memory.memory[1]  = itype(6'h08, 5'd0, 5'd13, 16'd7);
        dut.Instruction_Memory.memory[16] = itype(6'h08, 5'd0, 5'd14, 16'd9);
        boot(); run(2);
        chk("j pc", dut.PC.pc_o, 32'h40);
        run(10);
        chk("j flushes", 32'(flushes), 32'd1);
        chk("j stalls", 32'(stalls), 32'd0);
        chk("j r13", dut.Registers.register[13], 32'd0);
        chk("j r14", dut.Registers.register[14], 32'd9);

        // Store word then load it back
        clear_imem();
        dut.Registers.register[5] = 32'h12345678;
        dut.Instruction_Memory.memory[0] = itype(6'h2B, 5'd0, 5'd5, 16'd4);
        dut.Instruction_Memory.memory[1] = itype(6'h23, 5'd0, 5'd6, 16'd4);
        boot(); run(10);
        chk("sw m4", 32'(dut.DataMemory.memory[4]), 32'h78);
        chk("sw m5", 32'(dut.DataMemory.memory[5]), 32'h56);
        chk("sw m6", 32'(dut.DataMemory.memory[6]), 32'h34);
        chk("sw m7", 32'(dut.DataMemory.memory[7]), 32'h12);
        chk("lw r6", dut.Registers.register[6], 32'h12345678);

        // Reset mid-run leaves registers and memory alone; start=0 freezes PC
        clear_imem();
        for (int k = 0; k < 8; k++) begin
            dut.Registers.register[15 + k] = 32'hDEAD0000 + 32'(k);
            dut.Instruction_Memory.memory[k] = itype(6'h08, 5'd0, 5'(15 + k), 16'(11 * (k + 1)));
        end
        boot(); run(6);
        chk("mid r16", dut.Registers.register[16], 32'd22);
        for (int r = 0; r < 32; r++) snap_reg[r] = dut.Registers.register[r];
        for (int b = 0; b < 32; b++) snap_mem[b] = dut.DataMemory.memory[b];
        rst = 1'b1;
        run(1);
        chk("mid rst pc", dut.PC.pc_o, 32'h0);
        chk("mid rst hazard", 32'(dut.HazardDetection.MUX_Control_hazard_o), 32'h1);
        chk("mid rst flush", 32'(dut.Flush.flush_o), 32'h0);
        rst = 1'b0; start = 1'b0;
        run(8);
        chk("hold pc", dut.PC.pc_o, 32'h0);
        for (int r = 1; r < 32; r++)
            chk($sformatf("hold r%0d", r), dut.Registers.register[r], snap_reg[r]);
        for (int b = 0; b < 32; b += 4)
            chk($sformatf("hold m%0d", b), 32'(dut.DataMemory.memory[b]), 32'(snap_mem[b]));

        // Random straight-line programs against the ISA model
        for (int it = 0; it < 4; it++) begin
            int          exp_stalls, prev_lw_rt, kind;
            logic [31:0] ins, va, vb, sx;
            logic [4:0]  rs, rt, rd, a;
            logic [15:0] imm;
            clear_imem();
            mreg[0] = 32'h0;
            for (int r = 1; r < 32; r++) begin
                mreg[r] = $urandom;
                dut.Registers.register[r] = mreg[r];
            end
            for (int b = 0; b < 32; b++) begin
                mmem[b] = 8'($urandom);
                dut.DataMemory.memory[b] = mmem[b];
            end
            exp_stalls = 0;
            prev_lw_rt = -1;
            for (int k = 0; k < 20; k++) begin
                kind = $urandom_range(0, 7);
                rs   = 5'($urandom_range(0, 7));
                rt   = 5'($urandom_range(0, 7));
                rd   = 5'($urandom_range(0, 7));
                imm  = 16'($urandom);
                if (kind == 6) rt = 5'($urandom_range(1, 7));
                va = mreg[rs];
                vb = mreg[rt];
                sx = {{16{imm[15]}}, imm};
                a  = 5'(va + sx);
                case (kind)
                    0: begin ins = rtype(6'h20, rs, rt, rd); if (rd != 0) mreg[rd] = va + vb; end
                    1: begin ins = rtype(6'h22, rs, rt, rd); if (rd != 0) mreg[rd] = va - vb; end
                    2: begin ins = rtype(6'h24, rs, rt, rd); if (rd != 0) mreg[rd] = va & vb; end
                    3: begin ins = rtype(6'h25, rs, rt, rd); if (rd != 0) mreg[rd] = va | vb; end
                    4: begin ins = rtype(6'h18, rs, rt, rd); if (rd != 0) mreg[rd] = va * vb; end
                    5: begin ins = itype(6'h08, rs, rt, imm); if (rt != 0) mreg[rt] = va + sx; end
                    6: begin
                        ins = itype(6'h23, rs, rt, imm);
                        mreg[rt] = {mmem[5'(a + 5'd3)], mmem[5'(a + 5'd2)],
                                    mmem[5'(a + 5'd1)], mmem[a]};
                    end
                    default: begin
                        ins = itype(6'h2B, rs, rt, imm);
                        mmem[a]              = vb[7:0];
                        mmem[5'(a + 5'd1)]   = vb[15:8];
                        mmem[5'(a + 5'd2)]   = vb[23:16];
                        mmem[5'(a + 5'd3)]   = vb[31:24];
                    end
                endcase
                if (prev_lw_rt >= 0 && (prev_lw_rt == int'(ins[25:21]) || prev_lw_rt == int'(ins[20:16])))
                    exp_stalls++;
                prev_lw_rt = (kind == 6) ? int'(rt) : -1;
                dut.Instruction_Memory.memory[k] = ins;
            end
            boot(); run(50);
            chk($sformatf("rnd%0d stalls", it), 32'(stalls), 32'(exp_stalls));
            for (int r = 1; r < 32; r++)
                chk($sformatf("rnd%0d r%0d", it, r), dut.Registers.register[r], mreg[r]);
            for (int b = 0; b < 32; b++)
                chk($sformatf("rnd%0d m%0d", it, b), 32'(dut.DataMemory.memory[b]), 32'(mmem[b]));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
